mc_maindec: RTL and testbench
=============================

# mc_maindec

Multi-cycle main controller for the MIPS core, the successor to the single-cycle opcode decoder. It registers the opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It handshakes with a variable-latency memory through `mem_req`/`mem_ready` and drives the shared-ALU datapath's mux selects and write enables. It also counts retired instructions.

## Interface
- `EXT_OPS`, default 1: when 1, decode bne/andi/ori/slti; when 0, those opcodes are illegal.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `op`  in  6  opcode field from the instruction register, valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe, qualifies `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  load the instruction register.
- `pcwrite`  out  1  PC load enable.
- `pcsrc`  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = rs.
- `alusrcb`  out  2  ALU B select: 00 = rt, 01 = 4, 10 = immediate, 11 = immediate<<2.
- `aluop`  out  3  ALU op: 000 = add, 001 = sub, 010 = use funct, 011 = and, 100 = or, 101 = slt.
- `imm_zext`  out  1  zero-extend the immediate (andi/ori).
- `regwrite`  out  1  register-file write enable.
- `regdst`  out  1  destination register: 1 = rd, 0 = rt.
- `memtoreg`  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- `illegal`  out  1  one-cycle pulse on an undecodable opcode.
- `instret`  out  `CNT_W`  retired-instruction count.
- `state_o`  out  4  current state code, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, IEX=8, IWB=9, BRANCH=10, JUMP=11. Codes 12–15 are unreachable and recover to FETCH.
- Default for every output is 0. Only the values listed below are asserted.

States, outputs and transitions:
- **FETCH**
  - Drives `mem_req`=1, `alusrcb`=01, `aluop`=000, `pcsrc`=00.
  - If `mem_ready`=1: also drives `irwrite`=1 and `pcwrite`=1, then goes to DECODE.
  - Otherwise stays in FETCH.
- **DECODE**
  - Drives `alusrcb`=11, `aluop`=000 to compute the branch target.
  - Captures `op` into `op_q`.
  - Next state by opcode:
    - lw 100011 or sw 101011 → MEMADR
    - R-type 000000 → REX
    - addi 001000 → IEX
    - beq 000100 → BRANCH
    - j 000010 → JUMP
    - With `EXT_OPS`=1: bne 000101 → BRANCH; andi 001100, ori 001101, slti 001010 → IEX.
    - Anything else: `illegal`=1, next state FETCH, not counted as retired.
- **MEMADR**: `alusrca`=1, `alusrcb`=10, `aluop`=000. Goes to MEMRD if `op_q` is lw, otherwise MEMWR.
- **MEMRD**: `mem_req`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**: `regwrite`=1, `memtoreg`=1, `regdst`=0. Goes to FETCH.
- **MEMWR**: `mem_req`=1, `mem_we`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
- **REX**: `alusrca`=1, `alusrcb`=00, `aluop`=010. Goes to RWB.
- **RWB**: `regwrite`=1, `regdst`=1. Goes to FETCH.
- **IEX**
  - Drives `alusrca`=1, `alusrcb`=10.
  - `aluop` by `op_q`: addi → 000, andi → 011, ori → 100, slti → 101.
  - `imm_zext`=1 for andi/ori.
  - Goes to IWB.
- **IWB**: `regwrite`=1, `regdst`=0, `memtoreg`=0. Goes to FETCH.
- **BRANCH**
  - Drives `alusrca`=1, `alusrcb`=00, `aluop`=001, `pcsrc`=01.
  - `pcwrite` = `zero` for beq, `~zero` for bne.
  - Goes to FETCH.
- **JUMP**: `pcsrc`=10, `pcwrite`=1. Goes to FETCH.

Retired-instruction counter:
- `instret` increments by 1 on the cycle leaving MEMWB, MEMWR (on `mem_ready`), RWB, IWB, BRANCH or JUMP.
- It wraps modulo 2^`CNT_W`.

## Timing
- State register, `op_q` and `instret` are updated on the rising `clk` edge.
- Outputs are combinational from state and `op_q`. The exceptions are the Mealy terms: `irwrite`/`pcwrite` in FETCH (gated by `mem_ready`) and `pcwrite` in BRANCH (gated by `zero`).
- Reset behaviour:
  - While `resetn`=0: state=FETCH, `op_q`=0, `instret`=0, and all outputs forced to 0, including `mem_req`.
  - The first request is issued in the first cycle after `resetn` rises.
- Latency with zero-wait memory:
  - lw: 5 cycles
  - R-type, addi/andi/ori/slti, sw: 4 cycles
  - beq/bne, j: 3 cycles
  - Each cycle `mem_ready` is held low in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake rules:
  - `mem_req` and `mem_we`/`iord` remain stable until the `mem_ready` cycle.
  - `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-operation (e.g. in MEMWR waiting) takes effect immediately and asynchronously. No write completes and `instret` is not incremented.

## Test plan
- Reset, then `resetn` high with `mem_ready`=1: `mem_req`=1 in cycle 0, `irwrite`=`pcwrite`=1, `state_o` sequence 0,1.
- lw (`op`=100011) with `mem_ready` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. `regwrite`=`memtoreg`=1 only in state 4. `instret` 0→1.
- beq with `zero`=1, then `zero`=0: `pcwrite`=1 with `pcsrc`=01 in BRANCH for the first, `pcwrite`=0 for the second. bne with `zero`=0 gives `pcwrite`=1.
- ori (001101) with `EXT_OPS`=1: IEX drives `aluop`=100 and `imm_zext`=1, then IWB with `regwrite`=1, `regdst`=0. With `EXT_OPS`=0, the same opcode gives `illegal`=1 for one cycle, returns to FETCH, and `instret` is unchanged.
- R-type then j back to back, zero-wait: 7 cycles total, `instret` +2, `pcsrc`=10 in JUMP.
- sw with `resetn` pulled low during the MEMWR wait: outputs go to 0 immediately, state=0, `instret`=0. After release, a fresh fetch starts.

Source files
------------

// File: rtl/mc_maindec.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback,
// handshakes with variable-latency memory and counts retired instructions.
module mc_maindec #(
  parameter bit EXT_OPS = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       aluop,
  output logic             imm_zext,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB    = 4'd7,
    S_IEX    = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       imm_zext;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           r_state;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_instret;

  state_t w_next;
  logic   w_retire;
  ctl_t   w_ctl;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    w_ctl    = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.alusrcb = 2'b01;
        if (mem_ready) begin
          w_ctl.irwrite = 1'b1;
          w_ctl.pcwrite = 1'b1;
          w_next        = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_ctl.alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_REX;
          OP_ADDI:      w_next = S_IEX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_BNE: begin
            if (EXT_OPS) w_next = S_BRANCH;
            else         w_ctl.illegal = 1'b1;
          end
          OP_ANDI, OP_ORI, OP_SLTI: begin
            if (EXT_OPS) w_next = S_IEX;
            else         w_ctl.illegal = 1'b1;
          end
          default: w_ctl.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.alusrcb = 2'b10;
        w_next        = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.iord    = 1'b1;
        w_next        = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.memtoreg = 1'b1;
        w_retire       = 1'b1;
      end
      S_MEMWR: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.mem_we  = 1'b1;
        w_ctl.iord    = 1'b1;
        w_retire      = mem_ready;
        w_next        = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REX: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.aluop   = 3'b010;
        w_next        = S_RWB;
      end
      S_RWB: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.regdst   = 1'b1;
        w_retire       = 1'b1;
      end
      S_IEX: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.alusrcb = 2'b10;
        case (r_op_q)
          OP_ANDI: begin w_ctl.aluop = 3'b011; w_ctl.imm_zext = 1'b1; end
          OP_ORI:  begin w_ctl.aluop = 3'b100; w_ctl.imm_zext = 1'b1; end
          OP_SLTI: w_ctl.aluop = 3'b101;
          default: w_ctl.aluop = 3'b000;
        endcase
        w_next = S_IWB;
      end
      S_IWB: begin
        w_ctl.regwrite = 1'b1;
        w_retire       = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alusrca = 1'b1;
        w_ctl.aluop   = 3'b001;
        w_ctl.pcsrc   = 2'b01;
        w_ctl.pcwrite = (r_op_q == OP_BNE) ? ~zero : zero;
        w_retire      = 1'b1;
      end
      S_JUMP: begin
        w_ctl.pcsrc   = 2'b10;
        w_ctl.pcwrite = 1'b1;
        w_retire      = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are gated by resetn so the FETCH request cannot appear during reset.
  always_comb begin
    {mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
     aluop, imm_zext, regwrite, regdst, memtoreg, illegal} = resetn ? w_ctl : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_FETCH;
      r_op_q    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= op;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
  assign state_o = r_state;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed scoreboard bench for mc_maindec: one instance with extended opcodes,
// one without, compared cycle by cycle against expected state/control/count.
module tb_mc_maindec;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       imm_zext;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn_a, zero_a, ready_a;
  logic [5:0] op_a;
  logic       resetn_b, ready_b;
  logic [5:0] op_b;
  logic       sel_b;

  logic        a_mem_req, a_mem_we, a_iord, a_irwrite, a_pcwrite, a_alusrca;
  logic        a_imm_zext, a_regwrite, a_regdst, a_memtoreg, a_illegal;
  logic [1:0]  a_pcsrc, a_alusrcb;
  logic [2:0]  a_aluop;
  logic [31:0] a_instret;
  logic [3:0]  a_state;

  logic        b_mem_req, b_mem_we, b_iord, b_irwrite, b_pcwrite, b_alusrca;
  logic        b_imm_zext, b_regwrite, b_regdst, b_memtoreg, b_illegal;
  logic [1:0]  b_pcsrc, b_alusrcb;
  logic [2:0]  b_aluop;
  logic [31:0] b_instret;
  logic [3:0]  b_state;

  mc_maindec #(.EXT_OPS(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .resetn(resetn_a), .op(op_a), .zero(zero_a), .mem_ready(ready_a),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .irwrite(a_irwrite),
    .pcwrite(a_pcwrite), .pcsrc(a_pcsrc), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
    .aluop(a_aluop), .imm_zext(a_imm_zext), .regwrite(a_regwrite), .regdst(a_regdst),
    .memtoreg(a_memtoreg), .illegal(a_illegal), .instret(a_instret), .state_o(a_state)
  );

  mc_maindec #(.EXT_OPS(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .resetn(resetn_b), .op(op_b), .zero(1'b0), .mem_ready(ready_b),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .irwrite(b_irwrite),
    .pcwrite(b_pcwrite), .pcsrc(b_pcsrc), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
    .aluop(b_aluop), .imm_zext(b_imm_zext), .regwrite(b_regwrite), .regdst(b_regdst),
    .memtoreg(b_memtoreg), .illegal(b_illegal), .instret(b_instret), .state_o(b_state)
  );

  ctl_t        obs_ctl;
  logic [3:0]  obs_st;
  logic [31:0] obs_cnt;

  always_comb begin
    if (sel_b) begin
      obs_ctl = {b_mem_req, b_mem_we, b_iord, b_irwrite, b_pcwrite, b_pcsrc, b_alusrca,
                 b_alusrcb, b_aluop, b_imm_zext, b_regwrite, b_regdst, b_memtoreg, b_illegal};
      obs_st  = b_state;
      obs_cnt = b_instret;
    end else begin
      obs_ctl = {a_mem_req, a_mem_we, a_iord, a_irwrite, a_pcwrite, a_pcsrc, a_alusrca,
                 a_alusrcb, a_aluop, a_imm_zext, a_regwrite, a_regdst, a_memtoreg, a_illegal};
      obs_st  = a_state;
      obs_cnt = a_instret;
    end
  end

  // Expected control vectors, one per state, built from the controller's output table.
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy;
    return c;
  endfunction
  function automatic ctl_t c_decode(input logic ill);
    ctl_t c = '0;
    c.alusrcb = 2'b11; c.illegal = ill;
    return c;
  endfunction
  function automatic ctl_t c_memadr();
    ctl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_mem(input logic we);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = we;
    return c;
  endfunction
  function automatic ctl_t c_wb(input logic dst, input logic m2r);
    ctl_t c = '0;
    c.regwrite = 1'b1; c.regdst = dst; c.memtoreg = m2r;
    return c;
  endfunction
  function automatic ctl_t c_ex(input logic [1:0] srcb, input logic [2:0] alu, input logic zx);
    ctl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = srcb; c.aluop = alu; c.imm_zext = zx;
    return c;
  endfunction
  function automatic ctl_t c_branch(input logic pw);
    ctl_t c = '0;
    c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.pcwrite = pw;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.pcsrc = 2'b10; c.pcwrite = 1'b1;
    return c;
  endfunction

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input string tag, input logic [3:0] st, input ctl_t ctl,
                      input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.ctl = ctl; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs_st === e.st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, obs_st, e.st);
    end
    checks++;
    assert (obs_ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl: got %b expected %b", e.tag, obs_ctl, e.ctl);
    end
    checks++;
    assert (obs_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s instret: got %0d expected %0d", e.tag, obs_cnt, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel_b    = 1'b0;
    resetn_a = 1'b0; ready_a = 1'b1; zero_a = 1'b0; op_a = OP_RTYPE;
    resetn_b = 1'b0; ready_b = 1'b1; op_b = OP_ORI;

    step("reset_a", 4'd0, '0, 0);
    resetn_a = 1'b1;

    // R-type then j back to back, zero-wait: 7 cycles.
    step("r_fetch",  4'd0, c_fetch(1'b1), 0);
    step("r_decode", 4'd1, c_decode(1'b0), 0);
    step("r_rex",    4'd6, c_ex(2'b00, 3'b010, 1'b0), 0);
    step("r_rwb",    4'd7, c_wb(1'b1, 1'b0), 0);
    op_a = OP_J;
    step("j_fetch",  4'd0, c_fetch(1'b1), 1);
    step("j_decode", 4'd1, c_decode(1'b0), 1);
    step("j_jump",   4'd11, c_jump(), 1);

    // lw with two wait cycles in MEMRD.
    op_a = OP_LW;
    step("lw_fetch",  4'd0, c_fetch(1'b1), 2);
    step("lw_decode", 4'd1, c_decode(1'b0), 2);
    op_a = OP_RTYPE;
    step("lw_memadr", 4'd2, c_memadr(), 2);
    ready_a = 1'b0;
    step("lw_wait1",  4'd3, c_mem(1'b0), 2);
    step("lw_wait2",  4'd3, c_mem(1'b0), 2);
    ready_a = 1'b1;
    step("lw_rd",     4'd3, c_mem(1'b0), 2);
    step("lw_memwb",  4'd4, c_wb(1'b0, 1'b1), 2);

    // beq taken, beq not taken (after a fetch wait), bne taken.
    op_a = OP_BEQ; zero_a = 1'b1;
    step("beq1_fetch",  4'd0, c_fetch(1'b1), 3);
    step("beq1_decode", 4'd1, c_decode(1'b0), 3);
    step("beq1_branch", 4'd10, c_branch(1'b1), 3);
    zero_a = 1'b0; ready_a = 1'b0;
    step("beq0_fwait",  4'd0, c_fetch(1'b0), 4);
    ready_a = 1'b1;
    step("beq0_fetch",  4'd0, c_fetch(1'b1), 4);
    step("beq0_decode", 4'd1, c_decode(1'b0), 4);
    step("beq0_branch", 4'd10, c_branch(1'b0), 4);
    op_a = OP_BNE;
    step("bne_fetch",   4'd0, c_fetch(1'b1), 5);
    step("bne_decode",  4'd1, c_decode(1'b0), 5);
    step("bne_branch",  4'd10, c_branch(1'b1), 5);

    // ori with extended opcodes enabled.
    op_a = OP_ORI;
    step("ori_fetch",  4'd0, c_fetch(1'b1), 6);
    step("ori_decode", 4'd1, c_decode(1'b0), 6);
    step("ori_iex",    4'd8, c_ex(2'b10, 3'b100, 1'b1), 6);
    step("ori_iwb",    4'd9, c_wb(1'b0, 1'b0), 6);

    // sw aborted by reset while waiting in MEMWR.
    op_a = OP_SW;
    step("sw_fetch",  4'd0, c_fetch(1'b1), 7);
    step("sw_decode", 4'd1, c_decode(1'b0), 7);
    ready_a = 1'b0;
    step("sw_memadr", 4'd2, c_memadr(), 7);
    step("sw_wait",   4'd5, c_mem(1'b1), 7);
    #2 resetn_a = 1'b0;
    ready_a = 1'b1;
    step("sw_reset",  4'd0, '0, 0);
    resetn_a = 1'b1;
    step("post_reset_fetch", 4'd0, c_fetch(1'b1), 0);

    // Instance without extended opcodes: ori is illegal, addi still decodes.
    sel_b = 1'b1;
    step("reset_b", 4'd0, '0, 0);
    resetn_b = 1'b1;
    step("b_ori_fetch",  4'd0, c_fetch(1'b1), 0);
    step("b_ori_decode", 4'd1, c_decode(1'b1), 0);
    op_b = OP_ADDI;
    step("b_addi_fetch",  4'd0, c_fetch(1'b1), 0);
    step("b_addi_decode", 4'd1, c_decode(1'b0), 0);
    step("b_addi_iex",    4'd8, c_ex(2'b10, 3'b000, 1'b0), 0);
    step("b_addi_iwb",    4'd9, c_wb(1'b0, 1'b0), 0);
    step("b_next_fetch",  4'd0, c_fetch(1'b1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
